mul_initiator: RTL and testbench

//  Requester-side controller for the mulintf multiply handshake (a, b, en -> out, ack).

---
 rtl/mul_init_pkg.sv | 6 +
 rtl/mul_init_timer.sv | 18 +
 rtl/mul_initiator.sv | 112 +++++++++++
 tb/tb_mul_initiator.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mul_init_pkg.sv
// mul_init_pkg: shared state encoding and default sizes for the mulintf requester.
package mul_init_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, RESP} mul_init_state_e;
    localparam int DEF_OP_W        = 8;
    localparam int DEF_TIMEOUT_CYC = 16;
endpackage

// File: rtl/mul_init_timer.sv
// mul_init_timer: wait-cycle counter with terminal-count flag at TIMEOUT_CYC-1.
module mul_init_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (!reset_n || clr) cnt_q <= '0;
        else if (en && !tc)  cnt_q <= cnt_q + TW'(1);
    end
    assign tc = cnt_q == TW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/mul_initiator.sv
// mul_initiator: requester for the mulintf a/b/en -> out/ack handshake,
// with valid/ready command and result ports and a bounded ack wait.
module mul_initiator
    import mul_init_pkg::*;
#(
    parameter int OP_W        = DEF_OP_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_a,
    input  logic [OP_W-1:0]   cmd_b,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    output logic              mul_en,
    input  logic              mul_ack,
    input  logic [2*OP_W-1:0] mul_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*OP_W-1:0] res_data,
    output logic              res_err,
    output logic              busy,
    output logic [CNT_W-1:0]  job_count
);
    mul_init_state_e   state_q, state_d;
    logic [OP_W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic              mul_en_q, mul_en_d, res_valid_q, res_valid_d, res_err_q, res_err_d;
    logic [2*OP_W-1:0] res_data_q, res_data_d;
    logic [CNT_W-1:0]  job_count_q, job_count_d;
    logic              tc;

    // The timer restarts on every state change, so REQ and DRAIN each get a full budget.
    mul_init_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_d != state_q),
        .en      (state_q == REQ || state_q == DRAIN),
        .tc      (tc)
    );

    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_en_d    = mul_en_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        job_count_d = job_count_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                mul_a_d  = cmd_a;
                mul_b_d  = cmd_b;
                mul_en_d = 1'b1;
                state_d  = REQ;
            end
            REQ: if (mul_ack || tc) begin
                res_data_d = mul_ack ? mul_out : '0;
                res_err_d  = !mul_ack;
                mul_en_d   = 1'b0;
                state_d    = DRAIN;
            end
            DRAIN: if (!mul_ack || tc) begin
                res_err_d   = res_err_q || mul_ack;
                res_data_d  = mul_ack ? '0 : res_data_q;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: if (res_ready) begin
                res_valid_d = 1'b0;
                job_count_d = res_err_q ? job_count_q : job_count_q + CNT_W'(1);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            job_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_en_q    <= mul_en_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            job_count_q <= job_count_d;
        end
    end

    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_en    = mul_en_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign job_count = job_count_q;
endmodule

// File: tb/tb_mul_initiator.sv
// tb_mul_initiator: random jobs against a registered responder, checked against expected products and counts.
module tb_mul_initiator;
    localparam int TO = 16;
    localparam int CW = 4;
    logic        clk = 0, reset_n = 0, cmd_valid = 0, res_ready = 0;
    logic [7:0]  cmd_a = 0, cmd_b = 0, mul_a, mul_b;
    logic        cmd_ready, mul_en, mul_ack, res_valid, res_err, busy;
    logic [15:0] mul_out, res_data, rsp_out = 0;
    logic [CW-1:0] job_count;
    logic        rsp_ack = 0;
    int          mode = 0;
    int          total = 0, bad = 0, jc_m = 0;

    always #5 clk = ~clk;

    mul_initiator #(.OP_W(8), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
        .mul_ack(mul_ack), .mul_out(mul_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .busy(busy), .job_count(job_count)
    );

    // Responder: 1-cycle registered multiplier; mode 1 never acks, mode 2 acks forever.
    always @(posedge clk) begin
        rsp_ack <= mul_en;
        if (mul_en) rsp_out <= 16'(mul_a) * 16'(mul_b);
    end
    assign mul_ack = mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : rsp_ack;
    assign mul_out = rsp_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_job(input logic [7:0] a, input logic [7:0] b, input int hold);
        int n = 0, drop = 0;
        logic [15:0] exp_d = mode == 0 ? 16'(a) * 16'(b) : 16'd0;
        int exp_lat  = mode == 0 ? 4 : TO + 1;
        int exp_drop = mode == 0 ? 2 : mode == 1 ? TO : 1;
        cmd_a = a; cmd_b = b; cmd_valid = 1;
        chk("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 0;
        chk("mul_a", mul_a, a);
        chk("mul_b", mul_b, b);
        chk("mul_en_req", mul_en, 1);
        chk("busy", busy, 1);
        while (!res_valid && n < 100) begin
            tick();
            n++;
            if (!mul_en && drop == 0) drop = n;
        end
        chk("res_valid_seen", res_valid, 1);
        chk("latency", n, exp_lat);
        chk("en_drop", drop, exp_drop);
        for (int i = 0; i <= hold; i++) begin
            chk("res_data", res_data, exp_d);
            chk("res_err", res_err, mode != 0);
            chk("cmd_ready_busy", cmd_ready, 0);
            if (i < hold) tick();
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        if (mode == 0) jc_m = (jc_m + 1) % (1 << CW);
        chk("res_valid_done", res_valid, 0);
        chk("idle_gap", cmd_ready, 1);
        chk("job_count", job_count, jc_m);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_mul_en", mul_en, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_job_count", job_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_res_data", res_data, 0);
        reset_n = 1;
        tick();
        do_job(4, 10, 0);
        do_job(6, 12, 0);
        do_job(8, 16, 0);
        do_job(255, 255, 0);
        do_job(3, 7, 5);
        mode = 1;
        do_job(8'($urandom), 8'($urandom), 1);
        mode = 2;
        do_job(8'($urandom), 8'($urandom), 0);
        mode = 0;
        for (int k = 0; k < 20; k++)
            do_job(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        mode = 1;
        cmd_a = 9; cmd_b = 9; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        tick();
        reset_n = 0;
        tick();
        chk("mid_rst_mul_en", mul_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_job_count", job_count, 0);
        reset_n = 1;
        mode = 0;
        jc_m = 0;
        tick();
        do_job(2, 3, 0);
        chk("post_rst_result", res_data, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
